sys_umuladd: RTL and testbench
==============================

Name: sys_umuladd

Overview:
- Sequential unsigned multiply-accumulate: result = mul1*mul2 + add.
- Inverse companion of the multiply/divide helpers. Feeding a divider's quotient, divisor and remainder back in rebuilds the dividend (q*d + r).
- Used for ratio/clock-scaling round-trip checks and reconstruction in platform helpers.
- Same start/busy handshake as the other sys_* arithmetic helpers; shift-add, one multiplier bit per cycle.

Parameters:
- NB_MUL1, 16: width of mul1 (multiplicand).
- NB_MUL2, 16: width of mul2 (multiplier); sets iteration count.
- NB_ADD, 16: width of add; must be <= NB_MUL1+NB_MUL2 (elaboration-time assertion).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; operands sampled on the same edge.
- busy  out  1  high while the operation is in progress.
- done  out  1  one-cycle pulse on the cycle result becomes valid.
- mul1  in  NB_MUL1  multiplicand.
- mul2  in  NB_MUL2  multiplier.
- add  in  NB_ADD  addend.
- result  out  NB_MUL1+NB_MUL2+1  product plus addend; cannot overflow.

Behaviour:
- Clock and reset:
  - Single clock domain, clk. Reset is synchronous and active-low (reset_n).
  - Reset values: busy=0, done=0, result=0, state=IDLE, counter=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, load acc=zero-extend(add), mcand=zero-extend(mul1) to the result width, mplier=mul2, cnt=NB_MUL2-1.
  - Go to RUN; busy=1 from the next cycle.
- RUN, each cycle:
  - If mplier[0], acc <= acc + mcand.
  - mcand <<= 1; mplier >>= 1.
  - If cnt==0, go to DONE; else cnt--.
  - Fixed latency of NB_MUL2 RUN cycles; no early exit on zero operands.
- DONE (one cycle):
  - result <= acc; done=1; busy=0; go to IDLE.
  - result holds its value until the next completion.
- Latency: start at edge N; result valid and done=1 in cycle N+NB_MUL2+1; busy high for NB_MUL2 cycles.
- Start handling:
  - start while busy (RUN): ignored; the current operation completes unchanged.
  - start during DONE: ignored.
  - start is accepted again from the first IDLE cycle.
- Operands are sampled only at start; changes while busy have no effect.
- Width rule:
  - All internal arithmetic is NB_MUL1+NB_MUL2+1 bits.
  - Max value (2^a-1)(2^b-1)+(2^(a+b)-1) < 2^(a+b+1), so no truncation.
- Zero operands: mul1=0 or mul2=0 still takes full latency; result=add.
- reset_n=0 mid-operation:
  - Aborts the operation; all outputs return to reset values on that edge.
  - The next start after reset behaves normally.
- NB_MUL2=1: single RUN cycle.

Optional Feature:
- Macro: SYS_UMULADD_RADIX4_EN.
- Defined:
  - Two multiplier bits are retired per RUN cycle: acc += mcand*mplier[1:0] via {0, m, 2m, 3m}, with 3m precomputed at load.
  - mcand <<= 2; mplier >>= 2.
  - RUN lasts ceil(NB_MUL2/2) cycles; mul2 is zero-extended to an even width.
- Undefined: radix-2 as above.
- Handshake, done pulse and reset behaviour are identical in both builds.

Decomposition:
- Package sys_arith_pkg:
  - Typedef umuladd_state_t (IDLE/RUN/DONE).
  - Localparam function for iteration count (radix-2/radix-4) and for result width.
- One natural sub-module: sys_umuladd_step.
  - Combinational step: acc, mcand, mplier bits in; next acc out.
  - Radix selected by the macro.
  - Reusable by a future pipelined variant.

Test Plan:
- Reset, then idle: busy=0, done=0, result=0; start with mul1=0, mul2=0, add=0 -> result=0 after NB_MUL2+1 cycles.
- Defaults (16/16/16): mul1=0xFFFF, mul2=0xFFFF, add=0xFFFF -> result=0x0FFFF0000 (33 bits); done exactly at cycle 17 after start (9 with SYS_UMULADD_RADIX4_EN).
- Divider round-trip: mul1=1234 (quotient), mul2=56 (divisor), add=50 (remainder) -> result=69154.
- start re-pulsed mid-RUN with other operands -> ignored; result from the first operands; single done pulse.
- reset_n=0 at RUN cycle 5 -> busy=0, result=0 next edge; new start mul1=3, mul2=7, add=1 -> result=22.
- Back-to-back: start on the first IDLE cycle after done -> accepted; random 1000-vector sweep matches a*b+c, including mul2=0 (result=add).

Source files
------------

// File: rtl/sys_arith_pkg.sv
// Shared types and sizing helpers for the sys_* arithmetic helpers.
// Build option: SYS_UMULADD_RADIX4_EN retires two multiplier bits per RUN
// cycle in sys_umuladd instead of one.
package sys_arith_pkg;

  // Control states of the multiply-accumulate sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } umuladd_state_t;

  // Multiplier bits consumed per RUN cycle.
`ifdef SYS_UMULADD_RADIX4_EN
  localparam int unsigned UMULADD_DIGIT_W = 2;
`else
  localparam int unsigned UMULADD_DIGIT_W = 1;
`endif

  // Result width: one guard bit above the full product so that adding an
  // addend no wider than the product can never overflow.
  function automatic int unsigned umuladd_result_w(input int unsigned nb_mul1,
                                                   input int unsigned nb_mul2);
    return nb_mul1 + nb_mul2 + 1;
  endfunction

  // Number of RUN cycles needed to retire every multiplier bit.
  function automatic int unsigned umuladd_iters(input int unsigned nb_mul2);
    return (nb_mul2 + UMULADD_DIGIT_W - 1) / UMULADD_DIGIT_W;
  endfunction

  // Multiplier shift register width, rounded up to a whole number of digits.
  function automatic int unsigned umuladd_mplier_w(input int unsigned nb_mul2);
    return umuladd_iters(nb_mul2) * UMULADD_DIGIT_W;
  endfunction

endpackage

// File: rtl/sys_umuladd_step.sv
// One shift-add step of the unsigned multiply-accumulate: adds the
// multiplicand scaled by the current multiplier digit to the accumulator.
// Build option: SYS_UMULADD_RADIX4_EN selects a 2-bit digit, using a
// precomputed 3x multiplicand for the digit value 3.
module sys_umuladd_step #(
  parameter int unsigned RW = 33,
  parameter int unsigned DW = 1
) (
  input  logic [RW-1:0] acc_i,
  input  logic [RW-1:0] mcand_i,
`ifdef SYS_UMULADD_RADIX4_EN
  input  logic [RW-1:0] mcand3_i,
`endif
  input  logic [DW-1:0] digit_i,
  output logic [RW-1:0] acc_o
);

  // Select the scaled multiplicand for this digit and accumulate it.
  always_comb begin
    acc_o = acc_i;
`ifdef SYS_UMULADD_RADIX4_EN
    case (digit_i)
      2'd0:    acc_o = acc_i;
      2'd1:    acc_o = acc_i + mcand_i;
      2'd2:    acc_o = acc_i + (mcand_i << 1);
      default: acc_o = acc_i + mcand3_i;
    endcase
`else
    if (digit_i[0]) acc_o = acc_i + mcand_i;
`endif
  end

endmodule

// File: rtl/sys_umuladd.sv
// Sequential unsigned multiply-accumulate: result = mul1*mul2 + add.
// Rebuilds a divider's dividend from quotient, divisor and remainder.
// Build option: SYS_UMULADD_RADIX4_EN halves the RUN phase by retiring two
// multiplier bits per cycle; handshake and reset behaviour are unchanged.
//
// Handshake: start is a one-cycle request sampled together with the
// operands on a rising edge while the block is IDLE; starts in RUN or DONE
// are dropped. busy is high for every RUN cycle, done pulses for exactly one
// cycle with result valid, and result then holds until the next completion.
module sys_umuladd
  import sys_arith_pkg::*;
#(
  parameter int unsigned NB_MUL1 = 16,
  parameter int unsigned NB_MUL2 = 16,
  parameter int unsigned NB_ADD  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic [NB_MUL1-1:0]         mul1,
  input  logic [NB_MUL2-1:0]         mul2,
  input  logic [NB_ADD-1:0]          add,
  output logic [NB_MUL1+NB_MUL2:0]   result,
  output umuladd_state_t             dbg_state
);

  localparam int unsigned RW    = umuladd_result_w(NB_MUL1, NB_MUL2);
  localparam int unsigned DW    = UMULADD_DIGIT_W;
  localparam int unsigned ITERS = umuladd_iters(NB_MUL2);
  localparam int unsigned MW    = umuladd_mplier_w(NB_MUL2);
  localparam int unsigned CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ITERS - 1);

  // The addend must fit under the product so the guard bit suffices.
  if (NB_ADD > NB_MUL1 + NB_MUL2) begin : g_add_width_check
    $error("sys_umuladd: NB_ADD must not exceed NB_MUL1+NB_MUL2");
  end
  if (NB_MUL2 < 1) begin : g_mul2_width_check
    $error("sys_umuladd: NB_MUL2 must be at least 1");
  end

  umuladd_state_t state_q, state_d;
  logic [RW-1:0]  acc_q, acc_d;
  logic [RW-1:0]  mcand_q, mcand_d;
  logic [MW-1:0]  mplier_q, mplier_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  result_q, result_d;
  logic [RW-1:0]  acc_step;
`ifdef SYS_UMULADD_RADIX4_EN
  logic [RW-1:0]  mcand3_q, mcand3_d;
`endif

  sys_umuladd_step #(
    .RW (RW),
    .DW (DW)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
`ifdef SYS_UMULADD_RADIX4_EN
    .mcand3_i (mcand3_q),
`endif
    .digit_i  (mplier_q[DW-1:0]),
    .acc_o    (acc_step)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef SYS_UMULADD_RADIX4_EN
    mcand3_d = mcand3_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          acc_d    = RW'(add);
          mcand_d  = RW'(mul1);
          mplier_d = MW'(mul2);
          cnt_d    = CNT_LOAD;
`ifdef SYS_UMULADD_RADIX4_EN
          mcand3_d = RW'(mul1) + (RW'(mul1) << 1);
`endif
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << DW;
        mplier_d = mplier_q >> DW;
`ifdef SYS_UMULADD_RADIX4_EN
        mcand3_d = mcand3_q << DW;
`endif
        if (cnt_q == '0) begin
          // Capture on the last step so result is valid while done is high.
          state_d  = DONE;
          result_d = acc_step;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef SYS_UMULADD_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef SYS_UMULADD_RADIX4_EN
      mcand3_q <= mcand3_d;
`endif
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sys_umuladd.sv
// Directed and randomized checks of sys_umuladd (16/16/16) against a plain
// arithmetic model a*b+c.
module tb_sys_umuladd;
  import sys_arith_pkg::*;

`ifdef SYS_UMULADD_RADIX4_EN
  localparam int ITERS = 8;
`else
  localparam int ITERS = 16;
`endif
  localparam int TIMEOUT = 64;

  logic           clk;
  logic           reset_n;
  logic           start;
  logic           busy;
  logic           done;
  logic [15:0]    mul1;
  logic [15:0]    mul2;
  logic [15:0]    add;
  logic [32:0]    result;
  umuladd_state_t dbg_state;

  int n_tests;
  int n_fail;

  sys_umuladd #(
    .NB_MUL1 (16),
    .NB_MUL2 (16),
    .NB_ADD  (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mul1      (mul1),
    .mul2      (mul2),
    .add       (add),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic in 64 bits, truncated to the port.
  function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c);
    longint unsigned p;
    p = longint'(a) * longint'(b) + longint'(c);
    return p[32:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble operands while busy, wait for done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                        output logic [32:0] res, output int lat);
    @(negedge clk);
    mul1 = a; mul2 = b; add = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mul1 = 16'($urandom); mul2 = 16'($urandom); add = 16'($urandom);
    lat = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    res = result;
  endtask

  logic [32:0] res;
  int          lat;
  int          pulses;
  logic [32:0] captured;
  logic [15:0] ra, rb, rc;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    mul1    = '0;
    mul2    = '0;
    add     = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    reset_n = 1'b1;
    @(negedge clk);

    // All-zero operands still take full latency.
    run_op(16'd0, 16'd0, 16'd0, res, lat);
    check("zero_result", 64'(res), 64'd0);
    check("zero_latency", 64'(lat), 64'(ITERS));

    // Maximum operands: no overflow, exact latency, single done pulse.
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, res, lat);
    check("max_result", 64'(res), 64'h0_FFFF_0000);
    check("max_latency", 64'(lat), 64'(ITERS));
    check("max_busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    check("max_done_one_cycle", 64'(done), 64'd0);
    check("max_result_holds", 64'(result), 64'h0_FFFF_0000);

    // Divider round trip: q*d + r rebuilds the dividend.
    run_op(16'd1234, 16'd56, 16'd50, res, lat);
    check("roundtrip_result", 64'(res), 64'd69154);

    // start re-pulsed mid-RUN with other operands is ignored.
    @(negedge clk);
    mul1 = 16'd100; mul2 = 16'd200; add = 16'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("repulse_busy_before", 64'(busy), 64'd1);
    mul1 = 16'hAAAA; mul2 = 16'h5555; add = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses   = 0;
    captured = '0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        pulses++;
        captured = result;
      end
      @(negedge clk);
    end
    check("repulse_done_count", 64'(pulses), 64'd1);
    check("repulse_result", 64'(captured), 64'(model(16'd100, 16'd200, 16'd7)));

    // Reset asserted in RUN cycle 5 aborts the operation.
    @(negedge clk);
    mul1 = 16'hBEEF; mul2 = 16'hCAFE; add = 16'h0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    reset_n = 1'b1;
    run_op(16'd3, 16'd7, 16'd1, res, lat);
    check("after_abort_result", 64'(res), 64'd22);
    check("after_abort_latency", 64'(lat), 64'(ITERS));

    // start during DONE is ignored; start on the first IDLE cycle is taken.
    run_op(16'd9, 16'd11, 16'd5, res, lat);
    check("b2b_first_result", 64'(res), 64'd104);
    mul1 = 16'd2; mul2 = 16'd3; add = 16'd4; start = 1'b1;
    @(negedge clk);
    check("start_in_done_ignored", 64'(busy), 64'd0);
    mul1 = 16'd21; mul2 = 16'd13; add = 16'd8;
    @(negedge clk);
    start = 1'b0;
    check("b2b_accepted_busy", 64'(busy), 64'd1);
    lat = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_result", 64'(result), 64'd281);
    check("b2b_second_latency", 64'(lat), 64'(ITERS));

    // Random sweep, with mul2=0 and extreme values mixed in.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 16'd0;
        1: ra = 16'd0;
        2: begin ra = 16'hFFFF; rb = 16'hFFFF; end
        3: rc = 16'hFFFF;
        default: ;
      endcase
      run_op(ra, rb, rc, res, lat);
      check("rand_result", 64'(res), 64'(model(ra, rb, rc)));
      check("rand_latency", 64'(lat), 64'(ITERS));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
